serial_logic_unit: RTL and testbench

- Multi-cycle bitwise logic unit for the pipelined CPU's long-latency execute path.
- Accepts two DATA_SIZE-bit operands and an op code over a valid/ready handshake.
- Processes SLICE bits per cycle, least-significant slice first, and returns the full result plus optional flags over a valid/ready output handshake.

---
 rtl/serial_logic_unit.sv | 149 ++++++++++++++
 tb/tb_serial_logic_unit.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_logic_unit.sv
// serial_logic_unit: multi-cycle bitwise logic unit (AND/OR/XOR/ANDN).
// Operands are consumed SLICE bits per cycle, LSB slice first, and the
// result is assembled by shifting slices in from the MSB end.
// Optional registered zero/negative flags are enabled by the macro SLU_FLAGS_EN.
module serial_logic_unit #(
  parameter int unsigned DATA_SIZE = 64,
  parameter int unsigned SLICE     = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DATA_SIZE-1:0] a,
  input  logic [DATA_SIZE-1:0] b,
  input  logic [1:0]           op,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATA_SIZE-1:0] result,
  output logic                 zero,
  output logic                 negative
);

  localparam int unsigned N  = DATA_SIZE / SLICE;
  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [DATA_SIZE-1:0] a_q, a_d;
  logic [DATA_SIZE-1:0] b_q, b_d;
  logic [1:0]           op_q, op_d;
  logic [DATA_SIZE-1:0] res_q, res_d;
  logic [SLICE-1:0]     slice_s;
  logic [DATA_SIZE-1:0] res_shift;
  logic                 last_run;

  // Per-slice logic function on the low slice of the operand shifters
  always_comb begin
    slice_s = '0;
    unique case (op_q)
      2'b00: slice_s = a_q[SLICE-1:0] &  b_q[SLICE-1:0];
      2'b01: slice_s = a_q[SLICE-1:0] |  b_q[SLICE-1:0];
      2'b10: slice_s = a_q[SLICE-1:0] ^  b_q[SLICE-1:0];
      2'b11: slice_s = a_q[SLICE-1:0] & ~b_q[SLICE-1:0];
      default: slice_s = '0;
    endcase
  end

  // Concatenate-then-shift keeps the MSB-insertion valid even when N == 1
  assign res_shift = DATA_SIZE'({slice_s, res_q} >> SLICE);
  assign last_run  = (state_q == RUN) && (cnt_q == CW'(N - 1));

  // Next-state and datapath control
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    res_d   = res_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          op_d    = op;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        res_d = res_shift;
        a_d   = a_q >> SLICE;
        b_d   = b_q >> SLICE;
        if (last_run) begin
          state_d = DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      res_q   <= res_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign result    = res_q;

`ifdef SLU_FLAGS_EN
  logic zero_q, zero_d;
  logic neg_q, neg_d;

  // Flags are captured from the final assembled result on entry to DONE
  always_comb begin
    zero_d = zero_q;
    neg_d  = neg_q;
    if (last_run) begin
      zero_d = (res_shift == '0);
      neg_d  = res_shift[DATA_SIZE-1];
    end
  end

  // Flag registers
  always_ff @(posedge clk) begin
    if (reset) begin
      zero_q <= 1'b0;
      neg_q  <= 1'b0;
    end else begin
      zero_q <= zero_d;
      neg_q  <= neg_d;
    end
  end

  assign zero     = zero_q;
  assign negative = neg_q;
`else
  assign zero     = 1'b0;
  assign negative = 1'b0;
`endif

endmodule

// File: tb/tb_serial_logic_unit.sv
// Testbench for serial_logic_unit: scoreboard of expected results pushed at
// accept time and compared when out_valid rises; holds checked every DONE cycle.
module tb_serial_logic_unit;

`ifdef SLU_FLAGS_EN
  localparam bit FL = 1'b1;
`else
  localparam bit FL = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] a, b;
  logic [1:0]  op;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] result;
  logic        zero, negative;

  serial_logic_unit #(.DATA_SIZE(64), .SLICE(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .negative  (negative)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] res;
    logic        z;
    logic        n;
  } exp_t;

  exp_t exp_q[$];
  int   acc_q[$];
  exp_t cur;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  bit   prev_ov = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [63:0] model(input logic [63:0] x, input logic [63:0] y,
                                        input logic [1:0] o);
    case (o)
      2'b00:   return x & y;
      2'b01:   return x | y;
      2'b10:   return x ^ y;
      default: return x & ~y;
    endcase
  endfunction

  // Called at a negedge; returns at the negedge following the accepting edge
  task automatic send(input logic [63:0] ta, input logic [63:0] tb_v, input logic [1:0] top,
                      input bit push, input logic [63:0] er, input bit ez, input bit en,
                      output int acc);
    exp_t e;
    int unsigned n;
    a = ta; b = tb_v; op = top; in_valid = 1'b1; n = 0;
    while (in_ready !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) check("accept_timeout", {63'd0, in_ready}, 64'd1);
    acc = cyc + 1;
    if (push) begin
      e.res = er;
      e.z   = FL ? ez : 1'b0;
      e.n   = FL ? en : 1'b0;
      exp_q.push_back(e);
      acc_q.push_back(acc);
    end
    @(negedge clk);
    in_valid = 1'b0;
    check("busy_after_accept", {63'd0, in_ready}, 64'd0);
  endtask

  task automatic wait_idle();
    int unsigned n = 0;
    while (!(in_ready === 1'b1 && exp_q.size() == 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("idle_timeout", 64'(exp_q.size()), 64'd0);
  endtask

  // Output monitor: compare on out_valid rise, verify stability while held
  always @(negedge clk) begin
    int acc;
    if (out_valid === 1'b1 && !prev_ov) begin
      if (exp_q.size() == 0) begin
        check("spurious_out_valid", {63'd0, out_valid}, 64'd0);
      end else begin
        cur = exp_q.pop_front();
        acc = acc_q.pop_front();
        check("result", result, cur.res);
        check("zero", {63'd0, zero}, {63'd0, cur.z});
        check("negative", {63'd0, negative}, {63'd0, cur.n});
        check("latency", 64'(cyc - acc), 64'd8);
      end
    end else if (out_valid === 1'b1) begin
      check("hold_result", result, cur.res);
      check("hold_flags", {62'd0, zero, negative}, {62'd0, cur.z, cur.n});
    end
    prev_ov = (out_valid === 1'b1);
  end

  localparam logic [63:0] TA = 64'hFFFF_0000_F0F0_1234;
  localparam logic [63:0] TB = 64'h0F0F_FFFF_FF00_00FF;

  initial begin
    int acc, last_acc;
    logic [63:0] ra, rb;
    logic [1:0]  ro;
    logic [63:0] er;

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; op = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_result", result, 64'd0);
    check("rst_flags", {62'd0, zero, negative}, 64'd0);

    // Four ops on the reference operands
    send(TA, TB, 2'b00, 1'b1, 64'h0F0F_0000_F000_0034, 1'b0, 1'b0, acc);
    send(TA, TB, 2'b01, 1'b1, 64'hFFFF_FFFF_FFF0_12FF, 1'b0, 1'b1, acc);
    send(TA, TB, 2'b10, 1'b1, 64'hF0F0_FFFF_0FF0_12CB, 1'b0, 1'b1, acc);
    send(TA, TB, 2'b11, 1'b1, 64'hF0F0_0000_00F0_1200, 1'b0, 1'b1, acc);
    wait_idle();

    // Zero result, then hold in DONE while inputs toggle
    out_ready = 1'b0;
    send(64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555, 2'b00, 1'b1, 64'd0, 1'b1, 1'b0, acc);
    begin
      int unsigned n = 0;
      while (out_valid !== 1'b1 && n < 40) begin @(negedge clk); n++; end
      if (n >= 40) check("done_timeout", {63'd0, out_valid}, 64'd1);
    end
    for (int i = 0; i < 5; i++) begin
      a = {$urandom, $urandom}; b = {$urandom, $urandom};
      op = 2'($urandom); in_valid = ~in_valid;
      @(negedge clk);
      check("held_out_valid", {63'd0, out_valid}, 64'd1);
    end
    a = 64'h1234_5678_9ABC_DEF0; b = 64'h0F0F_0F0F_0F0F_0F0F; op = 2'b10;
    in_valid = 1'b1; out_ready = 1'b1;
    check("no_ready_in_done", {63'd0, in_ready}, 64'd0);
    @(negedge clk);
    check("retired_out_valid", {63'd0, out_valid}, 64'd0);
    check("no_accept_on_retire", {63'd0, in_ready}, 64'd1);
    send(64'h1234_5678_9ABC_DEF0, 64'h0F0F_0F0F_0F0F_0F0F, 2'b10, 1'b1,
         64'h1D3B_5977_95B3_D1FF, 1'b0, 1'b0, acc);
    wait_idle();

    // Reset during RUN cycle 4 discards the operation
    send(TA, TB, 2'b01, 1'b0, 64'd0, 1'b0, 1'b0, acc);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midrun_rst_in_ready", {63'd0, in_ready}, 64'd1);
    check("midrun_rst_result", result, 64'd0);
    check("midrun_rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("midrun_rst_flags", {62'd0, zero, negative}, 64'd0);
    repeat (12) @(negedge clk);
    send(64'h0000_0000_0000_0001, 64'h8000_0000_0000_0000, 2'b01, 1'b1,
         64'h8000_0000_0000_0001, 1'b0, 1'b1, acc);
    wait_idle();

    // Back-to-back random ops with in_valid/out_ready effectively held high
    last_acc = 0;
    for (int i = 0; i < 6; i++) begin
      ra = {$urandom, $urandom}; rb = {$urandom, $urandom}; ro = 2'($urandom);
      er = model(ra, rb, ro);
      send(ra, rb, ro, 1'b1, er, (er == 64'd0), er[63], acc);
      if (i > 0) check("issue_interval", 64'(acc - last_acc), 64'd10);
      last_acc = acc;
    end
    wait_idle();
    repeat (2) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
